// File: rtl/amm_arb_pkg.sv
// Shared types for the two-port Avalon-MM arbiter: FSM state encoding,
// read-ID FIFO entry layout and the zero-burst normalisation helper.
package amm_arb_pkg;

  localparam int BURST_W_MAX = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    WR_BURST = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                   id;
    logic [BURST_W_MAX-1:0] burstcount;
  } rd_entry_t;

  // A burstcount of 0 is illegal on Avalon-MM; it is handled as a single beat.
  function automatic logic [BURST_W_MAX-1:0] eff_burst(input logic [BURST_W_MAX-1:0] bc);
    return (bc == '0) ? BURST_W_MAX'(1) : bc;
  endfunction

endpackage

// File: rtl/amm_if.sv
// Avalon-MM pipelined/burst bus bundle; master drives commands, slave
// returns waitrequest and read data.
interface amm_if #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 11
) ();
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [BURST_W-1:0]  burstcount;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/amm_arb_rd_fifo.sv
// Synchronous FIFO of outstanding read commands {id, burstcount}; push and
// pop may occur in the same cycle. DEPTH must be a power of two, >= 2.
module amm_arb_rd_fifo
  import amm_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  rd_entry_t i_data,
  input  logic      i_pop,
  output rd_entry_t o_data,
  output logic      o_full,
  output logic      o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  rd_entry_t      r_mem [DEPTH];

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
        r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      end
      if (i_pop && !o_empty) begin
        r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/amm_arbiter.sv
// Two-requester Avalon-MM arbiter with burst hold and in-order read routing.
// Define AMM_ARBITER_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
//
// state    | meaning
// IDLE     | no grant; arbitrate pending requests
// CMD      | granted port connected; waiting for its command to be accepted
// WR_BURST | remaining beats of a write burst; grant held
module amm_arbiter
  import amm_arb_pkg::*;
#(
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 32,
  parameter int BURST_W       = 11,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  amm_if.slave   m0_if,
  amm_if.slave   m1_if,
  amm_if.master  mem_if
);
  arb_state_t             r_state;
  logic                   r_grant_id;
  logic [BURST_W_MAX-1:0] r_beat_cnt;
  logic [BURST_W_MAX-1:0] r_head_cnt;
  logic                   r_head_loaded;

  logic                   w_req0, w_req1, w_pick, w_active;
  logic                   w_g_read, w_g_write, w_g_wait;
  logic [BURST_W-1:0]     w_g_bc;
  logic [BURST_W_MAX-1:0] w_g_bc_eff, w_head_rem;
  logic                   w_fifo_full, w_fifo_empty;
  logic                   w_rd_acc, w_wr_acc, w_rsp_ok, w_pop;
  rd_entry_t              w_push_data, w_head;

  assign w_req0 = m0_if.read | m0_if.write;
  assign w_req1 = m1_if.read | m1_if.write;

`ifdef AMM_ARBITER_FIXED_PRIO_EN
  assign w_pick = ~w_req0;
`else
  logic r_last_id;
  assign w_pick = (w_req0 && w_req1) ? ~r_last_id : w_req1;
`endif

  assign w_active   = (r_state != IDLE);
  assign w_g_read   = r_grant_id ? m1_if.read       : m0_if.read;
  assign w_g_write  = r_grant_id ? m1_if.write      : m0_if.write;
  assign w_g_bc     = r_grant_id ? m1_if.burstcount : m0_if.burstcount;
  assign w_g_bc_eff = eff_burst(BURST_W_MAX'(w_g_bc));

  assign mem_if.address    = r_grant_id ? m1_if.address    : m0_if.address;
  assign mem_if.writedata  = r_grant_id ? m1_if.writedata  : m0_if.writedata;
  assign mem_if.byteenable = r_grant_id ? m1_if.byteenable : m0_if.byteenable;
  assign mem_if.burstcount = w_g_bc;
  assign mem_if.read       = w_active & w_g_read & ~w_fifo_full;
  assign mem_if.write      = w_active & w_g_write;

  // A read stalls on a full ID FIFO so its response can never be misrouted.
  assign w_g_wait = ~w_active | mem_if.waitrequest | (w_g_read & w_fifo_full);
  assign m0_if.waitrequest = r_grant_id ? 1'b1 : w_g_wait;
  assign m1_if.waitrequest = r_grant_id ? w_g_wait : 1'b1;

  assign w_rd_acc = (r_state == CMD) & mem_if.read & ~mem_if.waitrequest;
  assign w_wr_acc = w_active & mem_if.write & ~mem_if.waitrequest;

  assign w_push_data = '{id: r_grant_id, burstcount: w_g_bc_eff};

  amm_arb_rd_fifo #(.DEPTH(RD_FIFO_DEPTH)) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rd_acc),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_head_rem = r_head_loaded ? r_head_cnt : w_head.burstcount;
  assign w_rsp_ok   = mem_if.readdatavalid & ~w_fifo_empty;
  assign w_pop      = w_rsp_ok & (w_head_rem == BURST_W_MAX'(1));

  assign m0_if.readdata      = mem_if.readdata;
  assign m1_if.readdata      = mem_if.readdata;
  assign m0_if.readdatavalid = w_rsp_ok & (w_head.id == 1'b0);
  assign m1_if.readdatavalid = w_rsp_ok & (w_head.id == 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant_id    <= 1'b0;
      r_beat_cnt    <= '0;
      r_head_cnt    <= '0;
      r_head_loaded <= 1'b0;
`ifndef AMM_ARBITER_FIXED_PRIO_EN
      r_last_id     <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req0 || w_req1) begin
            r_grant_id <= w_pick;
`ifndef AMM_ARBITER_FIXED_PRIO_EN
            r_last_id  <= w_pick;
`endif
            r_state    <= CMD;
          end
        end
        CMD: begin
          if (w_rd_acc) begin
            r_state <= IDLE;
          end else if (w_wr_acc) begin
            if (w_g_bc_eff == BURST_W_MAX'(1)) begin
              r_state <= IDLE;
            end else begin
              r_beat_cnt <= w_g_bc_eff - BURST_W_MAX'(1);
              r_state    <= WR_BURST;
            end
          end
        end
        WR_BURST: begin
          if (w_wr_acc) begin
            r_beat_cnt <= r_beat_cnt - BURST_W_MAX'(1);
            if (r_beat_cnt <= BURST_W_MAX'(1)) begin
              r_beat_cnt <= '0;
              r_state    <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_rsp_ok) begin
        if (w_pop) begin
          r_head_loaded <= 1'b0;
          r_head_cnt    <= '0;
        end else begin
          r_head_loaded <= 1'b1;
          r_head_cnt    <= w_head_rem - BURST_W_MAX'(1);
        end
      end
    end
  end

endmodule
